// File: rtl/room_icon_drawer.sv
// room_icon_drawer: walks an ICON_W x ICON_H block (or the whole screen for a
// clear) one pixel per clock on the vga_adapter pixel-write interface, then
// raises countDone for a single cycle.
module room_icon_drawer #(
  parameter int         ICON_W    = 8,
  parameter int         ICON_H    = 8,
  parameter int         SCREEN_W  = 160,
  parameter int         SCREEN_H  = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_draw,
  input  logic       start_clear,
  input  logic [7:0] xcoord,
  input  logic [6:0] ycoord,
  input  logic [2:0] colour_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       countDone
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Scan limits for the two sweep kinds; the counters share one datapath.
  localparam logic [7:0] ICN_LAST_X = 8'(ICON_W - 1);
  localparam logic [6:0] ICN_LAST_Y = 7'(ICON_H - 1);
  localparam logic [7:0] CLR_LAST_X = 8'(SCREEN_W - 1);
  localparam logic [6:0] CLR_LAST_Y = 7'(SCREEN_H - 1);
  localparam logic [8:0] SCR_W9     = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H8     = 8'(SCREEN_H);

  state_t     state_q, state_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic [7:0] base_x_q, base_x_d;
  logic [6:0] base_y_q, base_y_d;
  logic [2:0] colour_q, colour_d;

  logic [7:0] last_x;
  logic [6:0] last_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       sweeping;

  // State, counters and latched base/colour; reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      colour_q <= colour_d;
    end
  end

  // Next-state logic: start sampling in IDLE, x-fastest scan in DRAW/CLEAR.
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    colour_d = colour_q;
    last_x   = (state_q == S_CLEAR) ? CLR_LAST_X : ICN_LAST_X;
    last_y   = (state_q == S_CLEAR) ? CLR_LAST_Y : ICN_LAST_Y;
    case (state_q)
      S_IDLE: begin
        if (start_clear) begin
          // A clear is just a sweep anchored at (0,0) in the background colour.
          state_d  = S_CLEAR;
          cx_d     = '0;
          cy_d     = '0;
          base_x_d = '0;
          base_y_d = '0;
          colour_d = BG_COLOUR;
        end else if (start_draw) begin
          state_d  = S_DRAW;
          cx_d     = '0;
          cy_d     = '0;
          base_x_d = xcoord;
          base_y_d = ycoord;
          colour_d = colour_in;
        end
      end
      S_DRAW, S_CLEAR: begin
        if (cx_q == last_x) begin
          cx_d = '0;
          if (cy_q == last_y) begin
            cy_d    = '0;
            state_d = S_DONE;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: widened sums so off-screen pixels are clipped, not wrapped.
  always_comb begin
    sum_x      = {1'b0, base_x_q} + {1'b0, cx_q};
    sum_y      = {1'b0, base_y_q} + {1'b0, cy_q};
    sweeping   = (state_q == S_DRAW) || (state_q == S_CLEAR);
    vga_x      = sweeping ? sum_x[7:0] : 8'd0;
    vga_y      = sweeping ? sum_y[6:0] : 7'd0;
    vga_colour = sweeping ? colour_q : 3'd0;
    vga_plot   = sweeping && (sum_x < SCR_W9) && (sum_y < SCR_H8);
    busy       = (state_q != S_IDLE);
    countDone  = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_room_icon_drawer.sv
// Testbench for room_icon_drawer: expected pixels are pushed to a queue when a
// sweep is started and popped against the pixels the DUT actually plots.
module tb_room_icon_drawer;

  logic       clock;
  logic       reset;
  logic       start_draw;
  logic       start_clear;
  logic [7:0] xcoord;
  logic [6:0] ycoord;
  logic [2:0] colour_in;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       countDone;

  int n_cmp = 0;
  int n_err = 0;

  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  room_icon_drawer dut (
    .clock      (clock),
    .reset      (reset),
    .start_draw (start_draw),
    .start_clear(start_clear),
    .xcoord     (xcoord),
    .ycoord     (ycoord),
    .colour_in  (colour_in),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .countDone  (countDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: push every on-screen pixel of an icon at (bx,by) in scan order.
  task automatic push_icon(input int bx, input int by, input logic [2:0] c);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (bx + x < 160 && by + y < 120)
          exp_q.push_back({8'(bx + x), 7'(by + y), c});
  endtask

  task automatic push_clear();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        exp_q.push_back({8'(x), 7'(y), 3'b000});
  endtask

  // Drive a start request so that it is sampled at the next rising edge.
  task automatic kick(input logic d, input logic c, input logic [7:0] x,
                      input logic [6:0] y, input logic [2:0] col);
    @(negedge clock);
    start_draw  = d;
    start_clear = c;
    xcoord      = x;
    ycoord      = y;
    colour_in   = col;
  endtask

  // Observe a sweep: record plotted pixels, the cycle index of countDone
  // (1 = cycle after the start edge), number of pulses and busy afterwards.
  task automatic watch(input int budget, input int poke_at, input logic [7:0] poke_x,
                       output int done_idx, output int pulses, output logic busy_after);
    obs_q.delete();
    done_idx   = 0;
    pulses     = 0;
    busy_after = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      start_draw  = 1'b0;
      start_clear = 1'b0;
      if (i == poke_at) begin
        start_draw = 1'b1;
        xcoord     = poke_x;
      end
      if (vga_plot) obs_q.push_back({vga_x, vga_y, vga_colour});
      if (countDone) begin
        pulses++;
        if (done_idx == 0) done_idx = i;
      end
      if (done_idx != 0 && i == done_idx + 1) begin
        busy_after = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_draw = 1'b0; start_clear = 1'b0;
    xcoord = 8'd0; ycoord = 7'd0; colour_in = 3'd0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({vga_plot, busy, countDone, vga_x, vga_y, vga_colour} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got plot=%b busy=%b done=%b x=%0d y=%0d c=%b, want all 0",
               vga_plot, busy, countDone, vga_x, vga_y, vga_colour);
    end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_draw();
    int di, np; logic ba; logic [17:0] e, o;
    push_icon(60, 73, 3'b100);
    kick(1'b1, 1'b0, 8'd60, 7'd73, 3'b100);
    watch(200, 0, 8'd0, di, np, ba);
    n_cmp++; if (di !== 65) begin n_err++; $display("FAIL draw_done_cycle: got %0d want 65", di); end
    n_cmp++; if (np !== 1) begin n_err++; $display("FAIL draw_done_pulses: got %0d want 1", np); end
    n_cmp++; if (ba !== 1'b0) begin n_err++; $display("FAIL draw_busy_after: got %b want 0", ba); end
    n_cmp++; if (obs_q.size() !== 64) begin n_err++; $display("FAIL draw_plot_count: got %0d want 64", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL draw_pixel: got %h want %h", o, e); break; end
    end
    exp_q.delete();
  endtask

  task automatic test_clip();
    int di, np; logic ba; logic [17:0] e, o;
    push_icon(156, 116, 3'b010);
    kick(1'b1, 1'b0, 8'd156, 7'd116, 3'b010);
    watch(200, 0, 8'd0, di, np, ba);
    n_cmp++; if (di !== 65) begin n_err++; $display("FAIL clip_done_cycle: got %0d want 65", di); end
    n_cmp++; if (np !== 1) begin n_err++; $display("FAIL clip_done_pulses: got %0d want 1", np); end
    n_cmp++; if (obs_q.size() !== 16) begin n_err++; $display("FAIL clip_plot_count: got %0d want 16", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL clip_pixel: got %h want %h", o, e); break; end
    end
    exp_q.delete();
  endtask

  task automatic test_clear(input logic also_draw);
    int di, np; logic ba; logic [17:0] e, o;
    push_clear();
    kick(also_draw, 1'b1, 8'd10, 7'd10, 3'b111);
    watch(19300, 0, 8'd0, di, np, ba);
    n_cmp++; if (di !== 19201) begin n_err++; $display("FAIL clear_done_cycle(both=%b): got %0d want 19201", also_draw, di); end
    n_cmp++; if (np !== 1) begin n_err++; $display("FAIL clear_done_pulses: got %0d want 1", np); end
    n_cmp++; if (obs_q.size() !== 19200) begin n_err++; $display("FAIL clear_plot_count: got %0d want 19200", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL clear_pixel(both=%b): got %h want %h", also_draw, o, e); break; end
    end
    exp_q.delete();
  endtask

  task automatic test_ignore_restart();
    int di, np; logic ba; logic [17:0] e, o;
    push_icon(20, 30, 3'b011);
    kick(1'b1, 1'b0, 8'd20, 7'd30, 3'b011);
    watch(200, 10, 8'd100, di, np, ba);
    n_cmp++; if (di !== 65) begin n_err++; $display("FAIL restart_done_cycle: got %0d want 65", di); end
    n_cmp++; if (np !== 1) begin n_err++; $display("FAIL restart_done_pulses: got %0d want 1", np); end
    n_cmp++; if (obs_q.size() !== 64) begin n_err++; $display("FAIL restart_plot_count: got %0d want 64", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL restart_pixel: got %h want %h", o, e); break; end
    end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    int di, np; logic ba; logic [17:0] e, o;
    kick(1'b1, 1'b0, 8'd40, 7'd50, 3'b101);
    @(negedge clock);
    start_draw = 1'b0;
    repeat (19) @(negedge clock);
    n_cmp++; if (vga_plot !== 1'b1) begin n_err++; $display("FAIL pre_reset_plot: got %b want 1", vga_plot); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({vga_plot, busy, countDone} !== 3'b000 || {vga_x, vga_y, vga_colour} !== 18'd0) begin
      n_err++;
      $display("FAIL async_reset: got plot=%b busy=%b done=%b x=%0d y=%0d c=%b want all 0",
               vga_plot, busy, countDone, vga_x, vga_y, vga_colour);
    end
    @(negedge clock);
    reset = 1'b0;
    push_icon(0, 0, 3'b110);
    kick(1'b1, 1'b0, 8'd0, 7'd0, 3'b110);
    watch(200, 0, 8'd0, di, np, ba);
    n_cmp++; if (di !== 65) begin n_err++; $display("FAIL post_reset_done_cycle: got %0d want 65", di); end
    n_cmp++; if (obs_q.size() !== 64) begin n_err++; $display("FAIL post_reset_plot_count: got %0d want 64", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL post_reset_pixel: got %h want %h", o, e); break; end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_draw();
    test_clip();
    test_clear(1'b0);
    test_clear(1'b1);
    test_ignore_restart();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
